// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared types and constants for the USB-controller SPI arbiter.
//   usb_state_t  : arbiter FSM state encoding
//   CMD_*        : field positions inside the SPI command byte
//   CNT_W        : width of the setup/hold interval counter
//   NUM_REQ      : number of requesters sharing the SPI link
// ---------------------------------------------------------------------------
package usb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_CMD   = 3'd2,
      ST_DATA  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DONE  = 3'd5
   } usb_state_t;

   // Command byte layout: [7:3] register address, [1] direction (1 = read).
   localparam int CMD_DIR_BIT  = 1;
   localparam int CMD_ADDR_MSB = 7;
   localparam int CMD_ADDR_LSB = 3;
   localparam int CMD_ADDR_W   = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;

   localparam int CNT_W   = 4;
   localparam int NUM_REQ = 2;

   function automatic logic cmd_is_read(input logic [7:0] cmd);
      return cmd[CMD_DIR_BIT];
   endfunction

   function automatic logic [CMD_ADDR_W-1:0] cmd_addr(input logic [7:0] cmd);
      return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
   endfunction

   // One-hot strobe for a two-requester index.
   function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/usb_rr_picker.sv
// ---------------------------------------------------------------------------
// usb_rr_picker
// Two-way round-robin choice, purely combinational.
//   valid  [1:0] in  : requests present this cycle
//   last         in  : index that won the previous arbitration
//   winner       out : index to serve (meaningful only when any = 1)
//   any          out : at least one request present
// A lone request always wins; on a tie the index that did not win last
// time is chosen, so the two requesters alternate under full load.
// ---------------------------------------------------------------------------
module usb_rr_picker (
   input  logic [1:0] valid,
   input  logic       last,
   output logic       winner,
   output logic       any
);

   always_comb begin
      any    = |valid;
      winner = last;
      unique case (valid)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last;
         default: winner = last;
      endcase
   end

endmodule

// File: rtl/usb_spi_arbiter.sv
// ---------------------------------------------------------------------------
// usb_spi_arbiter
// Shares one SPI byte engine between two requesters talking to the USB
// controller. Each transaction is a command byte followed by a data byte
// inside a single chip-select low window, with programmable setup and hold
// intervals around the two bytes.
//
// Parameters
//   SS_SETUP_CYCLES : clocks from n_ss_out low to the first spi_start_out (1..15)
//   SS_HOLD_CYCLES  : clocks from the data spi_done_in to n_ss_out high (1..15)
//
// Ports
//   clk_in         in   system clock, rising edge
//   n_rst_in       in   asynchronous active-low reset
//   req_valid_in   in   [1:0]      per-requester request, held until accepted
//   req_cmd_in     in   [1:0][7:0] per-requester command byte
//   req_wdata_in   in   [1:0][7:0] per-requester data byte
//   req_ready_out  out  [1:0]      one-cycle accept pulse to the winner
//   req_done_out   out  [1:0]      one-cycle completion pulse to the winner
//   rdata_out      out  [7:0]      byte read in the data phase, held
//   spi_start_out  out            one-cycle start to the byte engine
//   spi_tx_out     out  [7:0]      byte to send, stable until spi_done_in
//   spi_done_in    in             byte-complete pulse from the engine
//   spi_rx_in      in   [7:0]      received byte, valid with spi_done_in
//   n_ss_out       out            USB controller chip select, active-low
//   grant_out      out            index of the current/last granted requester
//
// State table
//   state  | meaning
//   IDLE   | n_ss_out high, waiting for a request to accept
//   SETUP  | n_ss_out low, counting setup clocks before the command byte
//   CMD    | command byte in flight, waiting for spi_done_in
//   DATA   | data byte in flight, capture spi_rx_in on spi_done_in
//   HOLD   | n_ss_out still low, counting hold clocks
//   DONE   | n_ss_out high, req_done_out pulsed to the granted requester
// ---------------------------------------------------------------------------
module usb_spi_arbiter
   import usb_pkg::*;
#(
   parameter int SS_SETUP_CYCLES = 2,
   parameter int SS_HOLD_CYCLES  = 2
) (
   input  logic                    clk_in,
   input  logic                    n_rst_in,
   input  logic [NUM_REQ-1:0]      req_valid_in,
   input  logic [NUM_REQ-1:0][7:0] req_cmd_in,
   input  logic [NUM_REQ-1:0][7:0] req_wdata_in,
   output logic [NUM_REQ-1:0]      req_ready_out,
   output logic [NUM_REQ-1:0]      req_done_out,
   output logic [7:0]              rdata_out,
   output logic                    spi_start_out,
   output logic [7:0]              spi_tx_out,
   input  logic                    spi_done_in,
   input  logic [7:0]              spi_rx_in,
   output logic                    n_ss_out,
   output logic                    grant_out
);

   // The counter runs from 0 on state entry, so the terminal value is N-1.
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SS_HOLD_CYCLES - 1);

   usb_state_t          state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [7:0]          cmd_q, cmd_nxt;
   logic [7:0]          wdata_q, wdata_nxt;

   logic [NUM_REQ-1:0]  ready_nxt;
   logic [NUM_REQ-1:0]  done_nxt;
   logic [7:0]          rdata_nxt;
   logic                start_nxt;
   logic [7:0]          tx_nxt;
   logic                ss_n_nxt;
   logic                grant_nxt;

   logic                pick_winner;
   logic                pick_any;

   usb_rr_picker u_picker (
      .valid  (req_valid_in),
      .last   (grant_out),
      .winner (pick_winner),
      .any    (pick_any)
   );

   always_ff @(posedge clk_in or negedge n_rst_in) begin
      if (!n_rst_in) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         cmd_q         <= '0;
         wdata_q       <= '0;
         req_ready_out <= '0;
         req_done_out  <= '0;
         rdata_out     <= '0;
         spi_start_out <= 1'b0;
         spi_tx_out    <= '0;
         n_ss_out      <= 1'b1;
         grant_out     <= 1'b1;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         cmd_q         <= cmd_nxt;
         wdata_q       <= wdata_nxt;
         req_ready_out <= ready_nxt;
         req_done_out  <= done_nxt;
         rdata_out     <= rdata_nxt;
         spi_start_out <= start_nxt;
         spi_tx_out    <= tx_nxt;
         n_ss_out      <= ss_n_nxt;
         grant_out     <= grant_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cmd_nxt   = cmd_q;
      wdata_nxt = wdata_q;
      ready_nxt = '0;
      done_nxt  = '0;
      rdata_nxt = rdata_out;
      start_nxt = 1'b0;
      tx_nxt    = spi_tx_out;
      ss_n_nxt  = n_ss_out;
      grant_nxt = grant_out;

      unique case (state)
         ST_IDLE: begin
            if (pick_any) begin
               ready_nxt = req_onehot(pick_winner);
               grant_nxt = pick_winner;
               cmd_nxt   = req_cmd_in[pick_winner];
               wdata_nxt = req_wdata_in[pick_winner];
               ss_n_nxt  = 1'b0;
               cnt_nxt   = '0;
               state_nxt = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (cnt == SETUP_LAST) begin
               start_nxt = 1'b1;
               tx_nxt    = cmd_q;
               state_nxt = ST_CMD;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         // A done that coincides with our own start pulse cannot belong to
         // the byte just launched, so it is ignored rather than double-starting.
         ST_CMD: begin
            if (spi_done_in && !spi_start_out) begin
               start_nxt = 1'b1;
               tx_nxt    = wdata_q;
               state_nxt = ST_DATA;
            end
         end

         ST_DATA: begin
            if (spi_done_in && !spi_start_out) begin
               rdata_nxt = spi_rx_in;
               cnt_nxt   = '0;
               state_nxt = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (cnt == HOLD_LAST) begin
               ss_n_nxt  = 1'b1;
               done_nxt  = req_onehot(grant_out);
               state_nxt = ST_DONE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         // One extra cycle with n_ss_out high before IDLE can accept again;
         // together with the DONE cycle this gives two high clocks minimum.
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end

         default: begin
            ss_n_nxt  = 1'b1;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   a_start_single: assert property (@(posedge clk_in) disable iff (!n_rst_in)
      spi_start_out |=> !spi_start_out);

   a_start_in_window: assert property (@(posedge clk_in) disable iff (!n_rst_in)
      spi_start_out |-> !n_ss_out);

   a_ready_onehot: assert property (@(posedge clk_in) disable iff (!n_rst_in)
      $onehot0(req_ready_out));

   a_done_onehot: assert property (@(posedge clk_in) disable iff (!n_rst_in)
      $onehot0(req_done_out));

endmodule

// File: tb/tb_usb_spi_arbiter.sv
module tb_usb_spi_arbiter;

   localparam int SETUP = 3;
   localparam int HOLD  = 2;

   logic            clk_in = 1'b0;
   logic            n_rst_in = 1'b1;
   logic [1:0]      req_valid_in;
   logic [1:0][7:0] req_cmd_in;
   logic [1:0][7:0] req_wdata_in;
   logic [1:0]      req_ready_out;
   logic [1:0]      req_done_out;
   logic [7:0]      rdata_out;
   logic            spi_start_out;
   logic [7:0]      spi_tx_out;
   logic            spi_done_in;
   logic [7:0]      spi_rx_in;
   logic            n_ss_out;
   logic            grant_out;

   logic            eng_done = 1'b0;
   logic            spur_pulse = 1'b0;
   assign spi_done_in = eng_done | spur_pulse;

   usb_spi_arbiter #(.SS_SETUP_CYCLES(SETUP), .SS_HOLD_CYCLES(HOLD)) dut (
      .clk_in        (clk_in),
      .n_rst_in      (n_rst_in),
      .req_valid_in  (req_valid_in),
      .req_cmd_in    (req_cmd_in),
      .req_wdata_in  (req_wdata_in),
      .req_ready_out (req_ready_out),
      .req_done_out  (req_done_out),
      .rdata_out     (rdata_out),
      .spi_start_out (spi_start_out),
      .spi_tx_out    (spi_tx_out),
      .spi_done_in   (spi_done_in),
      .spi_rx_in     (spi_rx_in),
      .n_ss_out      (n_ss_out),
      .grant_out     (grant_out)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: actual=timeout required=event", name);
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [1:0] mask;
      logic [7:0] cmd;
      logic [7:0] wd;
      logic [7:0] rdata;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] start_log[$];
   int         start_cnt = 0;

   // ---------------- SPI byte engine model ----------------
   // First byte of each transaction answers ~cur_rx (must be discarded),
   // second byte answers cur_rx.
   logic [7:0] cur_rx = 8'h00;
   int         engine_lat = 1;
   int         engine_phase = 0;

   initial begin
      spi_rx_in = 8'h00;
      forever begin
         @(posedge clk_in);
         #1;
         eng_done = 1'b0;
         if (n_rst_in && spi_start_out) begin
            repeat (engine_lat) @(posedge clk_in);
            #1;
            spi_rx_in    = (engine_phase == 0) ? ~cur_rx : cur_rx;
            engine_phase = 1 - engine_phase;
            eng_done     = 1'b1;
         end
      end
   end

   // ---------------- monitor ----------------
   int   su_cnt = 0;
   bit   su_track = 1'b0;
   int   ho_cnt = 0;
   bit   ho_track = 1'b0;
   int   hi_cnt = 100;
   logic ss_prev = 1'b1;

   always @(negedge clk_in) begin
      if (!n_rst_in) begin
         start_log.delete();
         su_track = 1'b0;
         ho_track = 1'b0;
         hi_cnt   = 100;
         ss_prev  = 1'b1;
      end else begin
         if (ss_prev && !n_ss_out) begin
            chk("ss_high_gap_ge2", 32'(hi_cnt >= 2), 32'(1));
            su_track = 1'b1;
            su_cnt   = 0;
         end
         hi_cnt = n_ss_out ? hi_cnt + 1 : 0;

         if (su_track) begin
            if (spi_start_out) begin
               chk("ss_setup_clocks", 32'(su_cnt), 32'(SETUP));
               su_track = 1'b0;
            end else begin
               su_cnt++;
            end
         end

         if (spi_start_out) begin
            start_log.push_back(spi_tx_out);
            start_cnt++;
         end

         if (spi_done_in && start_log.size() > 0)
            chk("tx_stable", 32'(spi_tx_out), 32'(start_log[$]));

         if (ho_track) begin
            if (n_ss_out) begin
               chk("ss_hold_clocks", 32'(ho_cnt), 32'(HOLD));
               ho_track = 1'b0;
            end else begin
               ho_cnt++;
            end
         end
         if (spi_done_in && start_log.size() == 2 && !ho_track) begin
            ho_track = 1'b1;
            ho_cnt   = 0;
         end

         if (|req_done_out) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(req_done_out), 32'(0));
            end else begin
               mon_e = exp_q.pop_front();
               chk("done_mask", 32'(req_done_out), 32'(mon_e.mask));
               chk("rdata", 32'(rdata_out), 32'(mon_e.rdata));
               chk("ss_high_at_done", 32'(n_ss_out), 32'(1));
               chk("start_count", 32'(start_log.size()), 32'(2));
               if (start_log.size() == 2) begin
                  chk("tx_cmd", 32'(start_log[0]), 32'(mon_e.cmd));
                  chk("tx_wdata", 32'(start_log[1]), 32'(mon_e.wd));
               end
            end
            start_log.delete();
         end
         ss_prev = n_ss_out;
      end
   end

   // ---------------- helpers ----------------
   task automatic check_reset();
      chk("rst_n_ss", 32'(n_ss_out), 32'(1));
      chk("rst_start", 32'(spi_start_out), 32'(0));
      chk("rst_ready", 32'(req_ready_out), 32'(0));
      chk("rst_done", 32'(req_done_out), 32'(0));
      chk("rst_rdata", 32'(rdata_out), 32'(0));
      chk("rst_tx", 32'(spi_tx_out), 32'(0));
      chk("rst_grant", 32'(grant_out), 32'(1));
   endtask

   task automatic apply_reset();
      @(negedge clk_in);
      n_rst_in = 1'b0;
      #1 check_reset();
      repeat (3) @(posedge clk_in);
      #1 n_rst_in = 1'b1;
      engine_phase = 0;
   endtask

   task automatic wait_ready(output logic [1:0] m, output bit ok);
      ok = 1'b0;
      m  = 2'b00;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_in);
         if (|req_ready_out) begin
            m  = req_ready_out;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("ready_wait");
   endtask

   task automatic wait_drain();
      bit done_ok;
      done_ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0) begin
            done_ok = 1'b1;
            break;
         end
         @(negedge clk_in);
      end
      if (!done_ok) begin
         timeout_fail("drain_wait");
         exp_q.delete();
      end
      repeat (2) @(negedge clk_in);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int         idx;
      logic [7:0] cmd;
      logic [7:0] wd;
      logic [7:0] rx;
      int         lat;
      bit         spur;
      logic [1:0] exp_mask;
      logic       exp_grant;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input vec_t v);
      logic [1:0] m;
      bit         ok;
      cur_rx     = v.rx;
      engine_lat = v.lat;
      @(negedge clk_in);
      req_cmd_in[v.idx]   = v.cmd;
      req_wdata_in[v.idx] = v.wd;
      req_valid_in[v.idx] = 1'b1;
      wait_ready(m, ok);
      if (ok) begin
         chk("ready_mask", 32'(m), 32'(v.exp_mask));
         chk("grant", 32'(grant_out), 32'(v.exp_grant));
         exp_q.push_back('{mask: v.exp_mask, cmd: v.cmd, wd: v.wd, rdata: v.exp_rdata});
      end
      req_valid_in[v.idx] = 1'b0;
      req_cmd_in[v.idx]   = ~v.cmd;
      req_wdata_in[v.idx] = ~v.wd;
      if (ok && v.spur) begin
         // Arbiter is in SETUP here: a stray done must not start anything.
         spur_pulse = 1'b1;
         @(posedge clk_in);
         #1 spur_pulse = 1'b0;
      end
      wait_drain();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [1:0] m;
      bit         ok;
      int         w;

      req_valid_in = 2'b00;
      req_cmd_in   = '0;
      req_wdata_in = '0;

      vecs[0] = '{0, 8'hA2, 8'h5C, 8'h3F, 1, 1'b0, 2'b01, 1'b0, 8'h3F};
      vecs[1] = '{1, 8'h13, 8'hC4, 8'h81, 3, 1'b1, 2'b10, 1'b1, 8'h81};
      vecs[2] = '{1, 8'hFF, 8'h00, 8'h00, 2, 1'b0, 2'b10, 1'b1, 8'h00};
      vecs[3] = '{0, 8'h00, 8'hFF, 8'hFF, 1, 1'b1, 2'b01, 1'b0, 8'hFF};
      vecs[4] = '{0, 8'h5A, 8'hA5, 8'h7E, 4, 1'b0, 2'b01, 1'b0, 8'h7E};

      apply_reset();

      // Stray done while idle.
      @(negedge clk_in);
      spur_pulse = 1'b1;
      @(posedge clk_in);
      #1 spur_pulse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         chk("idle_spur_start", 32'(spi_start_out), 32'(0));
         chk("idle_spur_ss", 32'(n_ss_out), 32'(1));
      end

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Reset while the data byte is in flight.
      cur_rx     = 8'h77;
      engine_lat = 6;
      start_cnt  = 0;
      @(negedge clk_in);
      req_cmd_in[0]   = 8'h11;
      req_wdata_in[0] = 8'h22;
      req_valid_in[0] = 1'b1;
      wait_ready(m, ok);
      req_valid_in[0] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_in);
         if (start_cnt >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("data_start_wait");
      @(negedge clk_in);
      n_rst_in = 1'b0;
      #1 check_reset();
      repeat (10) @(posedge clk_in);
      #1 n_rst_in = 1'b1;
      engine_phase = 0;
      run_vec(vecs[0]);

      // Both requesters valid from reset: strict alternation starting at 0.
      apply_reset();
      cur_rx     = 8'h99;
      engine_lat = 2;
      @(negedge clk_in);
      req_cmd_in[0]   = 8'h40;
      req_wdata_in[0] = 8'h01;
      req_cmd_in[1]   = 8'h4A;
      req_wdata_in[1] = 8'h02;
      req_valid_in    = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_ready(m, ok);
         if (ok) begin
            w = k % 2;
            chk("rr_ready", 32'(m), (w == 1) ? 32'(2) : 32'(1));
            chk("rr_grant", 32'(grant_out), 32'(w));
            exp_q.push_back('{mask: (w == 1) ? 2'b10 : 2'b01,
                              cmd: req_cmd_in[w], wd: req_wdata_in[w], rdata: 8'h99});
         end
      end
      req_valid_in = 2'b00;
      wait_drain();

      // Requester 1 back-to-back.
      cur_rx          = 8'h5A;
      engine_lat      = 1;
      req_cmd_in[1]   = 8'hC6;
      req_wdata_in[1] = 8'h3B;
      req_valid_in[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_ready(m, ok);
         if (ok) begin
            chk("b2b_ready", 32'(m), 32'(2));
            chk("b2b_grant", 32'(grant_out), 32'(1));
            exp_q.push_back('{mask: 2'b10, cmd: 8'hC6, wd: 8'h3B, rdata: 8'h5A});
         end
      end
      req_valid_in = 2'b00;
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
